mem_loader: RTL

Byte-stream loader that fills the processor's 40-bit data memory before a run. It accepts bytes over a valid/ready handshake, assembles them little-endian into DATA_W-bit words, and writes them to consecutive addresses from 0 to WORDS-1. While loading it holds `busy` high, which keeps the processor stalled. It is the write-side counterpart to the output capture path, which reads `data` words whenever `enable` is asserted.

---
 rtl/mem_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// Byte-stream loader: assembles little-endian bytes into DATA_W-bit words and
// writes them to addresses 0..WORDS-1, holding busy high while a session runs.
module mem_loader #(
  parameter int DATA_W = 40,
  parameter int WORDS  = 12,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  // state   | meaning
  // IDLE    | waiting for start, no bytes accepted
  // COLLECT | accepting bytes of the current word
  // WRITE   | one-cycle memory write of the assembled word
  // DONE    | one-cycle completion pulse after the last word

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  byte_idx;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] word_buf;
  logic              accept;

  // abort wins over a byte offered in the same cycle
  assign accept = (state == COLLECT) && byte_valid && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = COLLECT;
      end
      COLLECT: begin
        byte_ready = 1'b1;
        if (abort)                                state_nxt = IDLE;
        else if (accept && byte_idx == LAST_IDX)  state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (abort)                  state_nxt = IDLE;
        else if (addr == LAST_ADDR) state_nxt = DONE;
        else                        state_nxt = COLLECT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Assembly buffer is cleared only at session start: every byte lane is
  // rewritten before each WRITE, so stale lanes never reach memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      byte_idx <= '0;
      word_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr     <= '0;
            byte_idx <= '0;
            word_buf <= '0;
          end
        end
        COLLECT: begin
          if (abort) begin
            addr     <= '0;
            byte_idx <= '0;
          end else if (accept) begin
            word_buf[{byte_idx, 3'b000} +: 8] <= byte_in;
            byte_idx <= byte_idx + 1'b1;
          end
        end
        WRITE: begin
          byte_idx <= '0;
          if (abort)                   addr <= '0;
          else if (addr != LAST_ADDR)  addr <= addr + 1'b1;
        end
        DONE: begin
          addr     <= '0;
          byte_idx <= '0;
        end
        default: begin
          addr     <= '0;
          byte_idx <= '0;
        end
      endcase
    end
  end

  assign mem_addr  = addr;
  assign mem_wdata = word_buf;

endmodule
